// File: rtl/uart_rx_param.sv
// Parametrised UART receiver. It conditions the line with a synchroniser and
// a 3-sample majority vote, then frames start/data/parity/stop bits. Finished
// words are held in a one-entry valid/ready buffer that flags framing, parity
// and overrun errors.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 220,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sdin,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_BITS + 1);
  localparam int HALF  = CLKS_PER_BIT / 2;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  // Line conditioning: synchroniser, then a short history for the majority vote.
  logic       sync1_q, sync1_d;
  logic       sync2_q, sync2_d;
  logic [1:0] hist_q, hist_d;
  logic       sdin_s;
  logic       maj;

  // Frame assembly.
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 fe_acc_q, fe_acc_d;
  logic                 fe_next;
  logic                 cnt_end;
  logic                 done;

  // Output buffer.
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 pend_q, pend_d;
  logic                 busy_q, busy_d;
  logic                 read;

  assign sdin_s = sync2_q;

  // Synchroniser pipeline and the three-sample majority of the synchronised line.
  always_comb begin
    sync1_d = sdin;
    sync2_d = sync1_q;
    hist_d  = {hist_q[0], sdin_s};
    maj     = (sdin_s & hist_q[0]) | (sdin_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
  end

  // Receive FSM: times each bit with cnt and takes every decision at the bit centre.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    par_err_d = par_err_q;
    fe_acc_d  = fe_acc_q;
    fe_next   = fe_acc_q;
    done      = 1'b0;
    cnt_end   = (cnt_q == BIT_LAST);

    case (state_q)
      S_IDLE: begin
        cnt_d     = '0;
        idx_d     = '0;
        par_err_d = 1'b0;
        fe_acc_d  = 1'b0;
        if (!sdin_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = maj ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_end) begin
          cnt_d   = '0;
          shift_d = {maj, shift_q[DATA_BITS-1:1]};
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_PARITY: begin
        if (cnt_end) begin
          cnt_d     = '0;
          par_err_d = ((^shift_q) ^ maj) != PAR_ODD;
          state_d   = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_end) begin
          cnt_d    = '0;
          fe_next  = fe_acc_q | ~maj;
          fe_acc_d = fe_next;
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            done    = 1'b1;
            state_d = fe_next ? S_WAIT_HIGH : S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_HIGH: begin
        if (sdin_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output buffer: accepts a finished frame when empty or being read, else drops it.
  always_comb begin
    data_d       = data_q;
    valid_d      = valid_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    overrun_d    = overrun_q;
    pend_d       = pend_q;
    read         = valid_q && data_ready;

    if (done) begin
      if (!valid_q || read) begin
        data_d       = shift_q;
        valid_d      = 1'b1;
        frame_err_d  = fe_next;
        parity_err_d = par_err_q;
        overrun_d    = pend_q;
        pend_d       = 1'b0;
      end else begin
        overrun_d = 1'b1;
        pend_d    = 1'b1;
      end
    end else if (read) begin
      valid_d      = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
      overrun_d    = 1'b0;
      pend_d       = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // All state, including the registered outputs, updates here with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      hist_q       <= 2'b11;
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= '0;
      par_err_q    <= 1'b0;
      fe_acc_q     <= 1'b0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      pend_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      hist_q       <= hist_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      par_err_q    <= par_err_d;
      fe_acc_q     <= fe_acc_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      pend_q       <= pend_d;
      busy_q       <= busy_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Testbench for uart_rx_param. Three instances cover 8N1 at 16 clocks/bit,
// even parity at 16 clocks/bit, and 7 data bits with 2 stop bits at 220 clocks/bit.
// Expected words go into a per-instance queue when a frame is driven and are
// compared when the instance hands the word over.
module tb_uart_rx_param;

  localparam int CPB   = 16;
  localparam int LAT_A = 3 + CPB / 2 + (8 + 0 + 1) * CPB;
  localparam int LAT_P = 3 + CPB / 2 + (8 + 1 + 1) * CPB;
  localparam int LAT_S = 3 + 220 / 2 + (7 + 0 + 2) * 220;

  typedef struct {
    logic [8:0] data;
    logic       fe;
    logic       pe;
    logic       ov;
    int         start_cyc;
    bit         chk_lat;
    int         exp_lat;
  } exp_t;

  typedef struct {
    logic [7:0] value;
    int         glitch_bit;
    logic       stop_lvl;
    logic [7:0] exp_data;
    logic       exp_fe;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   tests = 0;
  int   failures = 0;

  logic       line_a, ready_a;
  logic [7:0] a_data;
  logic       a_valid, a_fe, a_pe, a_ov, a_busy;

  logic       line_p, ready_p;
  logic [7:0] p_data;
  logic       p_valid, p_fe, p_pe, p_ov, p_busy;

  logic       line_s, ready_s;
  logic [6:0] s_data;
  logic       s_valid, s_fe, s_pe, s_ov, s_busy;

  exp_t q_a[$];
  exp_t q_p[$];
  exp_t q_s[$];
  exp_t ea, ep, es;

  vec_t vecs[6];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .sdin(line_a), .data(a_data), .data_valid(a_valid),
    .data_ready(ready_a), .frame_err(a_fe), .parity_err(a_pe), .overrun(a_ov), .busy(a_busy)
  );

  uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
    .clk(clk), .reset(reset), .sdin(line_p), .data(p_data), .data_valid(p_valid),
    .data_ready(ready_p), .frame_err(p_fe), .parity_err(p_pe), .overrun(p_ov), .busy(p_busy)
  );

  uart_rx_param #(.CLKS_PER_BIT(220), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_s (
    .clk(clk), .reset(reset), .sdin(line_s), .data(s_data), .data_valid(s_valid),
    .data_ready(ready_s), .frame_err(s_fe), .parity_err(s_pe), .overrun(s_ov), .busy(s_busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic check_word(input string tag, input exp_t e, input logic [8:0] d,
                            input logic fe, input logic pe, input logic ov);
    int lat;
    checkOutput({tag, " data"}, 32'(d), 32'(e.data));
    checkOutput({tag, " frame_err"}, 32'(fe), 32'(e.fe));
    checkOutput({tag, " parity_err"}, 32'(pe), 32'(e.pe));
    checkOutput({tag, " overrun"}, 32'(ov), 32'(e.ov));
    if (e.chk_lat) begin
      lat = cyc - e.start_cyc;
      tests++;
      if (lat < e.exp_lat - 1 || lat > e.exp_lat + 1) begin
        failures++;
        $display("[TB] FAIL %s latency: got %0d cycles, expected %0d +/-1", tag, lat, e.exp_lat);
      end
    end
  endtask

  // Each monitor pops one expectation per completed handshake.
  always @(negedge clk) begin
    if (!reset && a_valid && ready_a) begin
      if (q_a.size() == 0) begin
        checkOutput("A spurious word valid", 32'(a_valid), 32'd0);
      end else begin
        ea = q_a.pop_front();
        check_word("A", ea, {1'b0, a_data}, a_fe, a_pe, a_ov);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && p_valid && ready_p) begin
      if (q_p.size() == 0) begin
        checkOutput("P spurious word valid", 32'(p_valid), 32'd0);
      end else begin
        ep = q_p.pop_front();
        check_word("P", ep, {1'b0, p_data}, p_fe, p_pe, p_ov);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && s_valid && ready_s) begin
      if (q_s.size() == 0) begin
        checkOutput("S spurious word valid", 32'(s_valid), 32'd0);
      end else begin
        es = q_s.pop_front();
        check_word("S", es, {2'b0, s_data}, s_fe, s_pe, s_ov);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    case (sel)
      0:       line_a = v;
      1:       line_p = v;
      default: line_s = v;
    endcase
  endtask

  task automatic drive_bit(input int sel, input logic b, input int cpb, input bit glitch);
    for (int c = 0; c < cpb; c++) begin
      set_line(sel, (glitch && c == cpb / 2 - 1) ? ~b : b);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int sel, input logic [8:0] val, input int nbits, input int cpb,
                               input bit has_par, input logic par_bit, input int nstop,
                               input logic stop_lvl, input int glitch_bit);
    drive_bit(sel, 1'b0, cpb, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(sel, val[i], cpb, i == glitch_bit);
    if (has_par) drive_bit(sel, par_bit, cpb, 1'b0);
    for (int i = 0; i < nstop; i++) drive_bit(sel, stop_lvl, cpb, 1'b0);
    set_line(sel, 1'b1);
  endtask

  task automatic expect_word(input int sel, input logic [8:0] d, input logic fe, input logic pe,
                             input logic ov, input bit chk, input int lat);
    exp_t e;
    e.data = d;
    e.fe = fe;
    e.pe = pe;
    e.ov = ov;
    e.start_cyc = cyc;
    e.chk_lat = chk;
    e.exp_lat = lat;
    case (sel)
      0:       q_a.push_back(e);
      1:       q_p.push_back(e);
      default: q_s.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int sel);
    case (sel)
      0:       return q_a.size();
      1:       return q_p.size();
      default: return q_s.size();
    endcase
  endfunction

  task automatic wait_drained(input int sel, input int budget, input string name);
    for (int i = 0; i < budget && qsize(sel) != 0; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput({name, " words outstanding"}, 32'(qsize(sel)), 32'd0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '{value: 8'hA5, glitch_bit: -1, stop_lvl: 1'b1, exp_data: 8'hA5, exp_fe: 1'b0};
    vecs[1] = '{value: 8'h00, glitch_bit: -1, stop_lvl: 1'b1, exp_data: 8'h00, exp_fe: 1'b0};
    vecs[2] = '{value: 8'hFF, glitch_bit: -1, stop_lvl: 1'b1, exp_data: 8'hFF, exp_fe: 1'b0};
    vecs[3] = '{value: 8'h96, glitch_bit: 0,  stop_lvl: 1'b1, exp_data: 8'h96, exp_fe: 1'b0};
    vecs[4] = '{value: 8'h3C, glitch_bit: 5,  stop_lvl: 1'b1, exp_data: 8'h3C, exp_fe: 1'b0};
    vecs[5] = '{value: 8'h55, glitch_bit: -1, stop_lvl: 1'b0, exp_data: 8'h55, exp_fe: 1'b1};

    reset   = 1'b1;
    line_a  = 1'b1;
    line_p  = 1'b1;
    line_s  = 1'b1;
    ready_a = 1'b1;
    ready_p = 1'b1;
    ready_s = 1'b1;
    wait_cycles(3);

    @(negedge clk);
    checkOutput("reset data", 32'(a_data), 32'd0);
    checkOutput("reset data_valid", 32'(a_valid), 32'd0);
    checkOutput("reset frame_err", 32'(a_fe), 32'd0);
    checkOutput("reset parity_err", 32'(a_pe), 32'd0);
    checkOutput("reset overrun", 32'(a_ov), 32'd0);
    checkOutput("reset busy", 32'(a_busy), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cycles(CPB);

    for (int i = 0; i < 6; i++) begin
      expect_word(0, {1'b0, vecs[i].exp_data}, vecs[i].exp_fe, 1'b0, 1'b0, 1'b1, LAT_A);
      applyStimulus(0, {1'b0, vecs[i].value}, 8, CPB, 1'b0, 1'b0, 1, vecs[i].stop_lvl, vecs[i].glitch_bit);
      wait_drained(0, 64, $sformatf("vec%0d", i));
      @(negedge clk);
      checkOutput($sformatf("vec%0d valid for one cycle", i), 32'(a_valid), 32'd0);
      @(posedge clk);
      #1;
      wait_cycles(2 * CPB);
    end

    // Short low glitch on an idle line is a false start.
    set_line(0, 1'b0);
    wait_cycles(4);
    set_line(0, 1'b1);
    wait_cycles(2);
    @(negedge clk);
    checkOutput("glitch busy during start check", 32'(a_busy), 32'd1);
    @(posedge clk);
    #1;
    wait_cycles(20);
    @(negedge clk);
    checkOutput("glitch busy released", 32'(a_busy), 32'd0);
    checkOutput("glitch no word", 32'(a_valid), 32'd0);
    @(posedge clk);
    #1;

    // Break: line low for 40 bit times gives one framing-error word.
    expect_word(0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1, LAT_A);
    set_line(0, 1'b0);
    wait_cycles(39 * CPB);
    @(negedge clk);
    checkOutput("break busy held", 32'(a_busy), 32'd1);
    checkOutput("break word count", 32'(q_a.size()), 32'd0);
    @(posedge clk);
    #1;
    wait_cycles(CPB - 1);
    set_line(0, 1'b1);
    wait_cycles(2 * CPB);
    @(negedge clk);
    checkOutput("break busy after release", 32'(a_busy), 32'd0);
    @(posedge clk);
    #1;
    expect_word(0, 9'h03C, 1'b0, 1'b0, 1'b0, 1'b1, LAT_A);
    applyStimulus(0, 9'h03C, 8, CPB, 1'b0, 1'b0, 1, 1'b1, -1);
    wait_drained(0, 64, "after break");
    wait_cycles(2 * CPB);

    // Overrun: consumer stalls through three back-to-back frames.
    ready_a = 1'b0;
    applyStimulus(0, 9'h011, 8, CPB, 1'b0, 1'b0, 1, 1'b1, -1);
    applyStimulus(0, 9'h022, 8, CPB, 1'b0, 1'b0, 1, 1'b1, -1);
    applyStimulus(0, 9'h033, 8, CPB, 1'b0, 1'b0, 1, 1'b1, -1);
    wait_cycles(8);
    @(negedge clk);
    checkOutput("ovr held valid", 32'(a_valid), 32'd1);
    checkOutput("ovr held data", 32'(a_data), 32'h11);
    checkOutput("ovr held overrun", 32'(a_ov), 32'd1);
    checkOutput("ovr held frame_err", 32'(a_fe), 32'd0);
    @(posedge clk);
    #1;
    expect_word(0, 9'h011, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    ready_a = 1'b1;
    @(posedge clk);
    #1;
    ready_a = 1'b0;
    @(negedge clk);
    checkOutput("ovr valid after read", 32'(a_valid), 32'd0);
    checkOutput("ovr flag after read", 32'(a_ov), 32'd0);
    checkOutput("ovr word consumed", 32'(q_a.size()), 32'd0);
    @(posedge clk);
    #1;
    wait_cycles(12 * CPB);
    @(negedge clk);
    checkOutput("ovr dropped frames stay lost", 32'(a_valid), 32'd0);
    @(posedge clk);
    #1;
    ready_a = 1'b1;
    wait_cycles(CPB);

    // Reset during data bit 4 of 0xFF abandons the frame.
    set_line(0, 1'b0);
    wait_cycles(CPB);
    set_line(0, 1'b1);
    wait_cycles(4 * CPB + CPB / 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    wait_cycles(3 * CPB);
    @(negedge clk);
    checkOutput("abort no word", 32'(a_valid), 32'd0);
    checkOutput("abort idle", 32'(a_busy), 32'd0);
    checkOutput("abort no frame_err", 32'(a_fe), 32'd0);
    @(posedge clk);
    #1;
    expect_word(0, 9'h05A, 1'b0, 1'b0, 1'b0, 1'b1, LAT_A);
    applyStimulus(0, 9'h05A, 8, CPB, 1'b0, 1'b0, 1, 1'b1, -1);
    wait_drained(0, 64, "after abort");

    // Even parity: 0x37 has five ones, so parity bit 1 is correct and 0 is wrong.
    expect_word(1, 9'h037, 1'b0, 1'b0, 1'b0, 1'b1, LAT_P);
    applyStimulus(1, 9'h037, 8, CPB, 1'b1, 1'b1, 1, 1'b1, -1);
    wait_drained(1, 64, "parity good");
    wait_cycles(2 * CPB);
    expect_word(1, 9'h037, 1'b0, 1'b1, 1'b0, 1'b1, LAT_P);
    applyStimulus(1, 9'h037, 8, CPB, 1'b1, 1'b0, 1, 1'b1, -1);
    wait_drained(1, 64, "parity bad");
    wait_cycles(2 * CPB);

    // Slow link, 7 data bits, 2 stop bits.
    expect_word(2, 9'h041, 1'b0, 1'b0, 1'b0, 1'b1, LAT_S);
    applyStimulus(2, 9'h041, 7, 220, 1'b0, 1'b0, 2, 1'b1, -1);
    wait_drained(2, 600, "slow 0x41");
    wait_cycles(50);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
